dual_port_ram: RTL

Parametrised successor to the single-port 8-bit system RAM: a true synchronous memory with one read/write port for the CPU and one independent read-only port for the video fetch path. Both ports return registered data with one-cycle latency. An optional hardware clear engine fills the whole array with a programmable value. It sits between the CPU bus and the tile/sprite renderer, and replaces the combinational-read RAM.

---
 rtl/dual_port_ram.sv | 132 +++++++++++++
 1 files changed

// File: rtl/dual_port_ram.sv
// dual_port_ram: synchronous memory with a CPU read/write port (A) and a
// video read-only port (B). Both ports return registered data one cycle
// after the address is presented, and reads are read-first.
// Optional hardware clear engine enabled with the RAM_CLEAR_EN macro: it fills
// the whole array with a latched value, one word per cycle. Port A writes are
// dropped while the fill runs.
module dual_port_ram #(
   parameter int AddrBits = 16,
   parameter int DataBits = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                aWriteEnabled,
   input  logic [AddrBits-1:0] aAddress,
   input  logic [DataBits-1:0] aDataIn,
   output logic [DataBits-1:0] aDataOut,
   input  logic [AddrBits-1:0] bAddress,
   output logic [DataBits-1:0] bDataOut
`ifdef RAM_CLEAR_EN
   ,
   input  logic                clearStart,
   input  logic [DataBits-1:0] clearValue,
   output logic                clearBusy,
   output logic                clearDone
`endif
);

   localparam int Depth = 1 << AddrBits;

   logic [DataBits-1:0] r_memory [Depth];
   logic [DataBits-1:0] r_aData;
   logic [DataBits-1:0] r_bData;

   logic                w_memWrite;
   logic [AddrBits-1:0] w_memAddr;
   logic [DataBits-1:0] w_memData;

`ifdef RAM_CLEAR_EN
   typedef enum logic {
      StIdle,
      StFill
   } clearState_t;

   // The counter carries one spare bit so the last-index compare never wraps.
   localparam logic [AddrBits:0] LastIndex = {1'b0, {AddrBits{1'b1}}};
   localparam logic [AddrBits:0] CountOne  = {{AddrBits{1'b0}}, 1'b1};

   clearState_t         r_state;
   logic [AddrBits:0]   r_counter;
   logic [DataBits-1:0] r_fillValue;
   logic                r_busy;
   logic                r_done;

   // Clear engine: latch the fill word on a start request, then walk every
   // address once; busy and done are registered alongside the state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= StIdle;
         r_counter   <= '0;
         r_fillValue <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            StIdle: begin
               if (clearStart) begin
                  r_fillValue <= clearValue;
                  r_counter   <= '0;
                  r_state     <= StFill;
                  r_busy      <= 1'b1;
               end
            end
            StFill: begin
               r_counter <= r_counter + CountOne;
               if (r_counter == LastIndex) begin
                  r_state <= StIdle;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
         endcase
      end
   end

   // Write-port arbitration: the fill owns the array, port A is dropped.
   always_comb begin
      w_memWrite = 1'b0;
      w_memAddr  = aAddress;
      w_memData  = aDataIn;
      if (r_state == StFill) begin
         w_memWrite = 1'b1;
         w_memAddr  = r_counter[AddrBits-1:0];
         w_memData  = r_fillValue;
      end else if (aWriteEnabled) begin
         w_memWrite = 1'b1;
      end
   end

   assign clearBusy = r_busy;
   assign clearDone = r_done;
`else
   // Without the clear engine port A always owns the write port.
   always_comb begin
      w_memWrite = aWriteEnabled;
      w_memAddr  = aAddress;
      w_memData  = aDataIn;
   end
`endif

   // Array write; contents are deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (w_memWrite) begin
         r_memory[w_memAddr] <= w_memData;
      end
   end

   // Registered reads on both ports; non-blocking update makes them read-first.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_aData <= '0;
         r_bData <= '0;
      end else begin
         r_aData <= r_memory[aAddress];
         r_bData <= r_memory[bAddress];
      end
   end

   assign aDataOut = r_aData;
   assign bDataOut = r_bData;

endmodule
